ysyx_25040101_ifu: RTL and testbench

Multi-cycle instruction fetch unit that sits directly upstream of the core datapath. It takes the next PC from the core at each instruction handshake and issues one read on a valid/ready address/data memory channel. It then presents the returned word, its PC and an error flag to decode through a valid/ready handshake. At most one fetch is outstanding; there is no speculation and no prefetch.

---
 rtl/ysyx_25040101_ifu.sv | 68 ++++++
 tb/tb_ysyx_25040101_ifu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040101_ifu.sv
// ysyx_25040101_ifu: multi-cycle instruction fetch unit with one outstanding read and a decode handshake
module ysyx_25040101_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_err_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  output logic [31:0] fetch_cnt_o
);
  localparam logic [1:0] REQ = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0] state;
  logic [31:0] pc_q;
  logic ar_hs;
  logic r_hs;
  logic d_hs;
  logic mis;
  assign arvalid_o = !rst && state == REQ;
  assign rready_o = !rst && state == WAIT;
  assign inst_valid_o = !rst && state == HOLD;
  assign araddr_o = pc_q;
  assign ar_hs = arvalid_o && arready_i;
  assign r_hs = rready_o && rvalid_i;
  assign d_hs = inst_valid_o && inst_ready_i;
  assign mis = next_pc_i[1:0] != 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc_q <= RESET_PC;
      inst_o <= 32'h0;
      inst_pc_o <= RESET_PC;
      inst_err_o <= 1'b0;
      fetch_cnt_o <= 32'h0;
    end else begin
      if (ar_hs)
        state <= WAIT;
      if (r_hs) begin
        state <= HOLD;
        inst_o <= rresp_i != 2'b00 ? 32'h0 : rdata_i;
        inst_pc_o <= pc_q;
        inst_err_o <= rresp_i != 2'b00;
      end
      if (d_hs) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
        pc_q <= next_pc_i;
        state <= mis ? HOLD : REQ;
        if (mis) begin
          inst_o <= 32'h0;
          inst_pc_o <= next_pc_i;
          inst_err_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// tb_ysyx_25040101_ifu: randomized memory/decode model with a scoreboard of expected instructions
module tb_ysyx_25040101_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] next_pc_i = 32'h0;
  logic inst_valid_o;
  logic inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic inst_err_o;
  logic arvalid_o;
  logic arready_i = 1'b0;
  logic [31:0] araddr_o;
  logic rvalid_i = 1'b0;
  logic rready_o;
  logic [31:0] rdata_i = 32'h0;
  logic [1:0] rresp_i = 2'b00;
  logic [31:0] fetch_cnt_o;
  exp_t q[$];
  logic [31:0] mpc = RESET_PC;
  int d_cur = 0;
  int a_fix = 0;
  int r_fix = 0;
  int d_fix = 0;
  logic np_use = 1'b1;
  logic [31:0] np_fix = 32'h8000_0004;
  logic dat_use = 1'b1;
  logic [31:0] dat_fix = 32'h0000_0413;
  logic [1:0] resp_fix = 2'b00;
  logic wrap_req = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_hs = 0;
  ysyx_25040101_ifu dut (
    .clk(clk),
    .rst(rst),
    .next_pc_i(next_pc_i),
    .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i),
    .inst_o(inst_o),
    .inst_pc_o(inst_pc_o),
    .inst_err_o(inst_err_o),
    .arvalid_o(arvalid_o),
    .arready_i(arready_i),
    .araddr_o(araddr_o),
    .rvalid_i(rvalid_i),
    .rready_o(rready_o),
    .rdata_i(rdata_i),
    .rresp_i(rresp_i),
    .fetch_cnt_o(fetch_cnt_o)
  );
  always #5 clk = ~clk;
  initial begin
    bit a_act;
    bit r_act;
    bit d_act;
    int a_need;
    int r_need;
    int a_cnt;
    int r_cnt;
    int d_cnt;
    a_act = 0;
    r_act = 0;
    d_act = 0;
    a_need = 0;
    r_need = 0;
    a_cnt = 0;
    r_cnt = 0;
    d_cnt = 0;
    forever begin
      @(negedge clk);
      arready_i = 1'b0;
      rvalid_i = 1'b0;
      rdata_i = $urandom;
      rresp_i = 2'($urandom);
      inst_ready_i = 1'($urandom);
      next_pc_i = $urandom;
      if (rst) begin
        rvalid_i = 1'b1;
        a_act = 0;
        r_act = 0;
        d_act = 0;
        q.delete();
        mpc = RESET_PC;
      end else begin
        if (arvalid_o) begin
          if (!a_act) begin
            a_act = 1;
            a_cnt = 0;
            a_need = a_fix < 0 ? int'($urandom_range(0, 3)) : a_fix;
          end
          arready_i = a_cnt == a_need;
          a_cnt++;
          if (arready_i) begin
            a_act = 0;
            rvalid_i = 1'($urandom);
          end
        end
        if (rready_o) begin
          if (!r_act) begin
            r_act = 1;
            r_cnt = 0;
            r_need = r_fix < 0 ? int'($urandom_range(0, 3)) : r_fix;
          end
          rvalid_i = r_cnt == r_need;
          r_cnt++;
          if (rvalid_i) begin
            r_act = 0;
            if (dat_use) begin
              rdata_i = dat_fix;
              rresp_i = resp_fix;
            end else
              rresp_i = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            q.push_back('{inst: rresp_i != 2'b00 ? 32'h0 : rdata_i, pc: mpc, err: rresp_i != 2'b00, lat: 3 + a_need + r_need});
          end
        end
        if (inst_valid_o) begin
          if (!d_act) begin
            d_act = 1;
            d_cnt = 0;
            d_cur = d_fix < 0 ? int'($urandom_range(0, 2)) : d_fix;
          end
          inst_ready_i = d_cnt == d_cur;
          d_cnt++;
          next_pc_i = np_use ? np_fix : RESET_PC + 32'($urandom_range(0, 1023) << 2) + 32'($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
          if (inst_ready_i) begin
            d_act = 0;
            mpc = next_pc_i;
            if (mpc[1:0] != 2'b00)
              q.push_back('{inst: 32'h0, pc: mpc, err: 1'b1, lat: 1});
          end
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    int cyc;
    int start;
    logic [31:0] ecnt;
    logic [1:0] shape;
    bit first;
    bit rst_prev;
    bit wrap_seen;
    cyc = 0;
    start = 0;
    ecnt = 32'h0;
    shape = 2'b10;
    first = 1;
    rst_prev = 1;
    wrap_seen = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (wrap_req != wrap_seen) begin
        wrap_seen = wrap_req;
        ecnt = 32'hFFFF_FFFF;
      end
      if (rst) begin
        if (rst_prev)
          chk("reset_outputs", 160'({arvalid_o, araddr_o, rready_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o, fetch_cnt_o}),
              160'({1'b0, RESET_PC, 1'b0, 1'b0, 32'h0, RESET_PC, 1'b0, 32'h0}));
        first = 1;
        shape = 2'b10;
        ecnt = 32'h0;
      end else begin
        if (first) begin
          first = 0;
          start = cyc;
          chk("arvalid_instvalid_after_handshake", 160'({arvalid_o, inst_valid_o}), 160'(shape));
        end
        chk("fetch_cnt", 160'(fetch_cnt_o), 160'(ecnt));
        if (arvalid_o)
          chk("araddr", 160'(araddr_o), 160'(mpc));
        if (inst_valid_o) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_inst: got inst_valid_o pc=%h expected no instruction", inst_pc_o);
          end else begin
            chk("inst_pc_err", 160'({inst_o, inst_pc_o, inst_err_o}), 160'({q[0].inst, q[0].pc, q[0].err}));
            if (inst_ready_i) begin
              chk("latency", 160'(cyc - start + 1), 160'(q[0].lat + d_cur));
              void'(q.pop_front());
              n_hs++;
              ecnt = ecnt + 32'd1;
              first = 1;
              shape = next_pc_i[1:0] != 2'b00 ? 2'b01 : 2'b10;
            end
          end
        end
      end
      rst_prev = rst;
    end
  end
  task automatic wait_hs(input int n);
    int target;
    target = n_hs + n;
    for (int i = 0; i < 100 * n + 100; i++) begin
      @(posedge clk);
      #1;
      if (n_hs >= target)
        return;
    end
    $display("FAIL handshake_timeout: got %0d handshakes expected %0d", n_hs, target);
    $fatal(1, "handshake timeout");
  endtask
  task automatic wait_rready();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rready_o)
        return;
    end
    $display("FAIL rready_timeout: got rready_o=0 expected 1 within 200 cycles");
    $fatal(1, "rready timeout");
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_hs(1);
    a_fix = 3;
    r_fix = 2;
    d_fix = 4;
    dat_fix = 32'h1234_5678;
    np_fix = 32'h8000_0010;
    wait_hs(1);
    a_fix = 0;
    r_fix = 0;
    d_fix = 0;
    dat_fix = 32'hDEAD_BEEF;
    resp_fix = 2'b10;
    np_fix = 32'h8000_0006;
    wait_hs(1);
    np_fix = 32'h8000_0008;
    dat_fix = 32'h0010_0093;
    resp_fix = 2'b00;
    wait_hs(2);
    a_fix = -1;
    r_fix = -1;
    d_fix = -1;
    np_use = 1'b0;
    dat_use = 1'b0;
    wait_hs(300);
    r_fix = 5;
    wait_rready();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r_fix = -1;
    wait_hs(5);
    r_fix = 3;
    wait_rready();
    force dut.fetch_cnt_o = 32'hFFFF_FFFF;
    wrap_req = ~wrap_req;
    @(posedge clk);
    #1 release dut.fetch_cnt_o;
    r_fix = -1;
    wait_hs(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
